// File: rtl/pending_index_encoder.sv
// pending_index_encoder: a 32-bit pending-bit set register feeding a 5-bit
// index encoder. It presents one pending index at a time on a valid/ready
// handshake. Priority is either fixed (lowest index wins) or rotating
// (ROUND_ROBIN=1, the search starts after the last served index).

// One pending bit. A set pulse beats a same-cycle serve, so a request that
// arrives while its bit is being served is presented again later.
module pending_index_encoder_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic set,
  input  logic served,
  output logic q
);
  // Sticky bit: clear on reset/clr, otherwise drop when served and set on req.
  always_ff @(posedge clk) begin
    if (reset || clr) q <= 1'b0;
    else              q <= (q & ~served) | set;
  end
endmodule

module pending_index_encoder #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req,
  input  logic        clr_all,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [31:0] pending,
  output logic [5:0]  count
);
  localparam int NUM_LANES = 32;
  localparam int IDX_W     = 5;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_served;
  logic                   handshake;
  logic [NUM_LANES-1:0]   served;
  logic [NUM_LANES-1:0]   search_src;
  logic [IDX_W-1:0]       search_base;
  logic [NUM_LANES-1:0]   above_mask;
  logic [NUM_LANES-1:0]   above;
  logic                   sel_any;
  logic [IDX_W-1:0]       sel_idx;

  // Lowest set bit of v; zero when v is empty (callers gate with sel_any).
  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_LANES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  assign handshake = out_valid & out_ready;
  assign served    = handshake ? (NUM_LANES'(1) << out_index) : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pending_index_encoder_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_all),
      .set    (req[g]),
      .served (served[g]),
      .q      (pending[g])
    );
  end

  // On a handshake the next pick excludes the bit being served and ignores
  // same-cycle req; the rotation base becomes the index just served.
  assign search_src  = handshake ? (pending & ~served) : pending;
  assign search_base = handshake ? out_index : last_served;

  // Pick the next index: lowest set bit, or first set bit above the base with wrap.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NUM_LANES; i++)
      above_mask[i] = (i > int'(search_base));
    above   = search_src & above_mask;
    sel_any = |search_src;
    if (ROUND_ROBIN != 0 && |above) sel_idx = lowest(above);
    else                            sel_idx = lowest(search_src);
  end

  // Population count of the registered pending vector.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_LANES; i++)
      count = count + 6'(pending[i]);
  end

  // Presentation FSM with registered valid/index; reset, then clr_all, dominate.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_index   <= '0;
      last_served <= IDX_W'(NUM_LANES - 1);
    end else if (clr_all) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            state     <= PRESENT;
            out_valid <= 1'b1;
            out_index <= sel_idx;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            last_served <= out_index;
            if (sel_any) begin
              out_index <= sel_idx;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pending_index_encoder.sv
// Directed bench for pending_index_encoder: one fixed-priority and one
// round-robin instance share the same stimulus; each task checks its scenario.
module tb_pending_index_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req;
  logic        clr_all;
  logic        out_ready;
  logic        v0, v1;
  logic [4:0]  i0, i1;
  logic [31:0] p0, p1;
  logic [5:0]  c0, c1;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pending_index_encoder #(.ROUND_ROBIN(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .clr_all(clr_all), .out_ready(out_ready),
    .out_valid(v0), .out_index(i0), .pending(p0), .count(c0));

  pending_index_encoder #(.ROUND_ROBIN(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .clr_all(clr_all), .out_ready(out_ready),
    .out_valid(v1), .out_index(i1), .pending(p1), .count(c1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; clr_all = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; clr_all = 1'b1; out_ready = 1'b1;
    tick();
    n_chk++; if (v0 !== 1'b0 || i0 !== 5'd0 || p0 !== 32'h0 || c0 !== 6'd0)
      $display("FAIL reset_fp got v=%0b i=%0d p=%h c=%0d want 0/0/0/0", v0, i0, p0, c0); else n_pass++;
    n_chk++; if (v1 !== 1'b0 || i1 !== 5'd0 || p1 !== 32'h0 || c1 !== 6'd0)
      $display("FAIL reset_rr got v=%0b i=%0d p=%h c=%0d want 0/0/0/0", v1, i1, p1, c1); else n_pass++;
    // first req right after reset release, latency 2
    reset = 1'b0; clr_all = 1'b0; out_ready = 1'b0; req = 32'h0000_0020;
    tick();
    req = '0;
    n_chk++; if (p0 !== 32'h20 || c0 !== 6'd1 || v0 !== 1'b0)
      $display("FAIL first_req_cap got p=%h c=%0d v=%0b want 20/1/0", p0, c0, v0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd5)
      $display("FAIL first_req_lat got v=%0b i=%0d want 1/5", v0, i0); else n_pass++;
  endtask

  task automatic test_fixed_basic();
    do_reset();
    req = 32'h0000_0090; out_ready = 1'b1;
    tick();
    req = '0;
    n_chk++; if (v0 !== 1'b0 || c0 !== 6'd2)
      $display("FAIL basic_cap got v=%0b c=%0d want 0/2", v0, c0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd4 || c0 !== 6'd2)
      $display("FAIL basic_first got v=%0b i=%0d c=%0d want 1/4/2", v0, i0, c0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd7 || c0 !== 6'd1)
      $display("FAIL basic_second got v=%0b i=%0d c=%0d want 1/7/1", v0, i0, c0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b0 || c0 !== 6'd0)
      $display("FAIL basic_done got v=%0b c=%0d want 0/0", v0, c0); else n_pass++;
  endtask

  task automatic test_stall();
    logic [4:0] exp_idx [2];
    exp_idx[0] = 5'd1; exp_idx[1] = 5'd31;
    do_reset();
    req = 32'h8000_0001;
    tick();
    req = '0;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd0 || c0 !== 6'd2)
      $display("FAIL stall_start got v=%0b i=%0d c=%0d want 1/0/2", v0, i0, c0); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      req = (c == 1) ? 32'h2 : 32'h0;
      tick();
      n_chk++; if (v0 !== 1'b1 || i0 !== 5'd0)
        $display("FAIL stall_hold cyc=%0d got v=%0b i=%0d want 1/0", c, v0, i0); else n_pass++;
    end
    req = '0;
    n_chk++; if (c0 !== 6'd3 || p0 !== 32'h8000_0003)
      $display("FAIL stall_count got c=%0d p=%h want 3/80000003", c0, p0); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++; if (v0 !== 1'b1 || i0 !== exp_idx[k] || c0 !== 6'(2 - k))
        $display("FAIL stall_seq k=%0d got v=%0b i=%0d c=%0d want 1/%0d/%0d", k, v0, i0, c0, exp_idx[k], 2 - k);
      else n_pass++;
    end
    tick();
    n_chk++; if (v0 !== 1'b0 || c0 !== 6'd0)
      $display("FAIL stall_done got v=%0b c=%0d want 0/0", v0, c0); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_set_wins();
    do_reset();
    req = 32'h8;
    tick();
    req = '0;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd3)
      $display("FAIL setwin_pres got v=%0b i=%0d want 1/3", v0, i0); else n_pass++;
    out_ready = 1'b1; req = 32'h9;
    tick();
    req = '0;
    n_chk++; if (p0 !== 32'h9 || v0 !== 1'b0)
      $display("FAIL setwin_keep got p=%h v=%0b want 9/0", p0, v0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd0)
      $display("FAIL setwin_low got v=%0b i=%0d want 1/0", v0, i0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd3 || p0 !== 32'h8 || c0 !== 6'd1)
      $display("FAIL setwin_again got v=%0b i=%0d p=%h c=%0d want 1/3/8/1", v0, i0, p0, c0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b0 || p0 !== 32'h0)
      $display("FAIL setwin_done got v=%0b p=%h want 0/0", v0, p0); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_idx [3];
    exp_idx[0] = 5'd1; exp_idx[1] = 5'd2; exp_idx[2] = 5'd0;
    do_reset();
    req = 32'h7;
    tick();
    req = '0;
    tick();
    n_chk++; if (v1 !== 1'b1 || i1 !== 5'd0)
      $display("FAIL rr_first got v=%0b i=%0d want 1/0", v1, i1); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req = (k == 1) ? 32'h1 : 32'h0;   // inject bit 0 while index 1 is served
      tick();
      n_chk++; if (v1 !== 1'b1 || i1 !== exp_idx[k])
        $display("FAIL rr_seq k=%0d got v=%0b i=%0d want 1/%0d", k, v1, i1, exp_idx[k]); else n_pass++;
    end
    req = '0;
    tick();
    n_chk++; if (v1 !== 1'b0 || p1 !== 32'h0)
      $display("FAIL rr_done got v=%0b p=%h want 0/0", v1, p1); else n_pass++;
    // last served is 0: rotation picks 3 before 0, fixed picks 0 first
    out_ready = 1'b0; req = 32'h9;
    tick();
    req = '0;
    tick();
    n_chk++; if (i1 !== 5'd3 || i0 !== 5'd0 || v1 !== 1'b1 || v0 !== 1'b1)
      $display("FAIL rr_vs_fp got rr=%0d fp=%0d want 3/0", i1, i0); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_chk++; if (i1 !== 5'd0 || i0 !== 5'd3)
      $display("FAIL rr_wrap got rr=%0d fp=%0d want 0/3", i1, i0); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_all_bits();
    do_reset();
    out_ready = 1'b1; req = '1;
    tick();
    req = '0;
    n_chk++; if (c0 !== 6'd32 || v0 !== 1'b0)
      $display("FAIL all_cap got c=%0d v=%0b want 32/0", c0, v0); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      tick();
      n_chk++; if (v0 !== 1'b1 || i0 !== 5'(k) || c0 !== 6'(32 - k) || v1 !== 1'b1 || i1 !== 5'(k))
        $display("FAIL all_seq k=%0d got fp=%0d rr=%0d c=%0d v=%0b want %0d/%0d/%0d/1", k, i0, i1, c0, v0, k, k, 32 - k);
      else n_pass++;
    end
    tick();
    n_chk++; if (v0 !== 1'b0 || c0 !== 6'd0 || v1 !== 1'b0)
      $display("FAIL all_done got v0=%0b v1=%0b c=%0d want 0/0/0", v0, v1, c0); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    req = 32'h30;
    tick();
    req = '0;
    tick();
    n_chk++; if (v0 !== 1'b1 || i0 !== 5'd4)
      $display("FAIL clr_pres got v=%0b i=%0d want 1/4", v0, i0); else n_pass++;
    clr_all = 1'b1; req = 32'h100; out_ready = 1'b1;
    tick();
    clr_all = 1'b0; req = '0; out_ready = 1'b0;
    n_chk++; if (p0 !== 32'h0 || v0 !== 1'b0 || c0 !== 6'd0)
      $display("FAIL clr_mid got p=%h v=%0b c=%0d want 0/0/0", p0, v0, c0); else n_pass++;
    tick();
    n_chk++; if (v0 !== 1'b0 || p0 !== 32'h0)
      $display("FAIL clr_stay got v=%0b p=%h want 0/0", v0, p0); else n_pass++;
    // reset mid-present with req and ready active
    req = 32'h30;
    tick();
    req = '0;
    tick();
    reset = 1'b1; req = 32'h100; out_ready = 1'b1;
    tick();
    reset = 1'b0; req = '0; out_ready = 1'b0;
    n_chk++; if (p0 !== 32'h0 || v0 !== 1'b0 || c0 !== 6'd0 || i0 !== 5'd0)
      $display("FAIL rst_mid got p=%h v=%0b c=%0d i=%0d want 0/0/0/0", p0, v0, c0, i0); else n_pass++;
    // clr_all beats a same-cycle handshake: last served stays at 0, not 1
    out_ready = 1'b1; req = 32'h3;
    tick();
    req = '0;
    tick();
    tick();
    n_chk++; if (i1 !== 5'd1 || v1 !== 1'b1)
      $display("FAIL clr_ls_pre got v=%0b i=%0d want 1/1", v1, i1); else n_pass++;
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0; out_ready = 1'b0; req = 32'h3;
    tick();
    req = '0;
    tick();
    n_chk++; if (i1 !== 5'd1 || i0 !== 5'd0 || v1 !== 1'b1)
      $display("FAIL clr_ls_keep got rr=%0d fp=%0d want 1/0", i1, i0); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; req = '0; clr_all = 1'b0; out_ready = 1'b0;
    tick();
    test_reset();
    test_fixed_basic();
    test_stall();
    test_set_wins();
    test_round_robin();
    test_all_bits();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pending_index_encoder.md
PENDING_INDEX_ENCODER -- requirements
Module: pending_index_encoder

Interface
REQ-001 The block SHALL have parameter ROUND_ROBIN, default 0: 0 = fixed priority (lowest index wins), 1 = rotating priority starting after the last-served index.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  32  set pulses; each high bit sets the matching pending bit.
REQ-005 The block SHALL have port clr_all  input  1  synchronous clear of all pending bits and of the output.
REQ-006 The block SHALL have port out_ready  input  1  consumer accepts out_index this cycle.
REQ-007 The block SHALL have port out_valid  output  1  out_index holds a pending, unserved index.
REQ-008 The block SHALL have port out_index  output  5  encoded index (0..31) of the selected pending bit.
REQ-009 The block SHALL have port pending  output  32  registered pending vector.
REQ-010 The block SHALL have port count  output  6  population count of pending (0..32), combinational from the pending register.

Function
REQ-011 The block SHALL encode the 32-bit pending vector into the 5-bit index; it is the inverse of the 5-to-32 register-select decode.
REQ-012 The pending update SHALL be: pending_next = (pending & ~served) | req, where served is the one-hot of out_index when out_valid & out_ready, else zero.
REQ-013 When a req bit and the served bit coincide, set SHALL win; the bit stays pending and is re-presented later.
REQ-014 req SHALL reach pending one cycle later; the earliest out_valid for a req into an idle block is the cycle after that (latency 2 clk).
REQ-015 The FSM SHALL have two states: IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-016 In IDLE with pending != 0, the FSM SHALL load out_index with the selected index and go to PRESENT; with pending == 0 it SHALL stay in IDLE.
REQ-017 In PRESENT with out_ready=0, out_index SHALL hold stable, even if new lower-priority or higher-priority req bits arrive.
REQ-018 In PRESENT with out_ready=1 (handshake), the FSM SHALL select from pending & ~served (excluding same-cycle req). If that is nonzero, it SHALL load the new index and stay in PRESENT (one index per cycle sustained); otherwise it SHALL go to IDLE.
REQ-019 With ROUND_ROBIN=0, selection SHALL be the lowest set bit index.
REQ-020 With ROUND_ROBIN=1, selection SHALL be the first set bit at index > last_served, searching upward with wrap from 31 to 0. last_served updates on each handshake and resets to 31, so the first search starts at 0.
REQ-021 The bit being presented SHALL remain set in pending and counted in count until its handshake.
REQ-022 On clr_all=1, pending SHALL clear to 0 and the FSM SHALL go to IDLE next cycle; clr_all SHALL dominate req and handshake in the same cycle, and last_served SHALL be unchanged.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 While reset=1 at a clk edge, the block SHALL set pending=0, FSM=IDLE, out_valid=0, out_index=0, last_served=31; count SHALL therefore read 0.
REQ-025 reset SHALL dominate clr_all, req and out_ready; reset mid-PRESENT SHALL drop out_valid with no served bit recorded.
REQ-026 The first req sampled after reset deasserts SHALL be captured normally.

Verification
REQ-027 Scenario: ROUND_ROBIN=0, req=0x0000_0090 for one cycle, out_ready=1 -> out_index 4 then 7 on consecutive cycles, then out_valid=0, count 2->1->0.
REQ-028 Scenario: stall: pending 0x8000_0001 presenting 0, out_ready=0 for 5 cycles while req=0x0000_0002 arrives -> out_index stays 0 and count becomes 3; after release, out_index sequence is 0,1,31.
REQ-029 Scenario: set-wins: presenting index 3, out_ready=1 with req=0x0000_0008 same cycle -> bit 3 still pending, and index 3 is presented again once no lower bit is pending.
REQ-030 Scenario: ROUND_ROBIN=1, pending 0x0000_0007, serve 1 then inject req bit 0 -> sequence 0,1,2,0 (wrap order honoured, no starvation).
REQ-031 Scenario: all 32 bits set, out_ready=1 -> 32 consecutive handshakes, indices 0..31, count decrements 32->0.
REQ-032 Scenario: clr_all and, separately, reset asserted mid-PRESENT with req active same cycle -> next cycle pending=0, out_valid=0, count=0.
